seq_steer_driver: RTL and testbench

Input-side driver for the two-T-flip-flop sequential circuit (`seq_circuit`). It accepts a target state on a valid/ready command port and drives the circuit's serial input `x` one bit per clock along the shortest path to that state, using an internal model of the circuit. When the circuit is in the target state, it returns a response carrying the step count. It sits in front of `seq_circuit`, sharing its `clk` and `reset`, so the circuit's state can be set by command instead of by hand-written stimulus.

---
 rtl/seq_pkg.sv | 42 ++++
 rtl/seq_steer_driver.sv | 111 +++++++++++
 tb/tb_seq_steer_driver.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the two-T-flip-flop circuit and its steering driver:
// state encoding, driver FSM states, the circuit next-state and steer functions.
package seq_pkg;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t S00 = 2'b00;
  localparam seq_state_t S01 = 2'b01;
  localparam seq_state_t S10 = 2'b10;
  localparam seq_state_t S11 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEER = 2'd1,
    ST_RESP  = 2'd2
  } drv_state_e;

  // Next state of seq_circuit for serial input x.
  function automatic seq_state_t seq_next(input seq_state_t state, input logic x);
    seq_state_t nxt;
    case (state)
      S00:     nxt = x ? S11 : S00;
      S01:     nxt = x ? S10 : S11;
      S10:     nxt = S11;
      default: nxt = x ? S11 : S01;
    endcase
    return nxt;
  endfunction

  // First move on the shortest path from cur towards tgt (tgt != cur, tgt != 00).
  function automatic logic seq_steer_x(input seq_state_t cur, input seq_state_t tgt);
    logic xs;
    case (cur)
      S00:     xs = 1'b1;
      S11:     xs = 1'b0;
      S01:     xs = (tgt == S10);
      default: xs = 1'b1;
    endcase
    return xs;
  endfunction

endpackage

// File: rtl/seq_steer_driver.sv
// Steers seq_circuit to a commanded state via its serial input x and reports the step count.
// Optional SEQ_STEER_CHECK_EN adds a sticky model-vs-observed state compare on chk_err.
module seq_steer_driver (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_target,
  output logic       x,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_steps,
  output logic       rsp_err,
  input  logic [1:0] obs_state,
  output logic       chk_err
);
  import seq_pkg::*;

  drv_state_e state_q;
  seq_state_t mdl_q, mdl_d;
  seq_state_t tgt_q;
  logic [1:0] steps_q;
  logic       err_q;
  logic       cmd_ready_q;
  logic       rsp_valid_q;

  // x depends only on registered state; the idle policy |mdl parks the circuit in 00 or 11.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    x = |mdl_q;
    if (state_q == ST_STEER && mdl_q != tgt_q && tgt_q != S00)
      x = seq_steer_x(mdl_q, tgt_q);
  end

  assign mdl_d = seq_next(mdl_q, x);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mdl_q <= S00;
    else       mdl_q <= mdl_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tgt_q       <= S00;
      steps_q     <= 2'd0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            tgt_q       <= cmd_target;
            steps_q     <= 2'd0;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_STEER;
          end
        end
        ST_STEER: begin
          if (mdl_q == tgt_q) begin
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (tgt_q == S00) begin
            // 00 has no incoming transition other than reset.
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            steps_q <= steps_q + 2'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_steps = steps_q;
  assign rsp_err   = err_q;

`ifdef SEQ_STEER_CHECK_EN
  logic chk_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   chk_err_q <= 1'b0;
    else if (obs_state != mdl_q) chk_err_q <= 1'b1;
  end

  assign chk_err = chk_err_q;
`else
  logic unused_obs;
  assign unused_obs = ^obs_state;
  assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_seq_steer_driver.sv
// Directed bench for seq_steer_driver with a seq_circuit model on x and a response scoreboard.
module tb_seq_steer_driver;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_target;
  logic       x;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_steps;
  logic       rsp_err;
  logic [1:0] obs_state;
  logic       chk_err;

  logic [1:0] circ_q;
  logic       force_obs;
  logic [1:0] obs_force_val;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    logic [1:0] steps;
    logic       err;
    int         lat;
    logic [3:0] xs;
    logic [7:0] obs;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seq_steer_driver dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .x          (x),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_steps  (rsp_steps),
    .rsp_err    (rsp_err),
    .obs_state  (obs_state),
    .chk_err    (chk_err)
  );

  // The circuit being steered; its state feeds back as obs_state.
  always @(posedge clk or posedge reset) begin
    if (reset) circ_q <= 2'b00;
    else       circ_q <= seq_next(circ_q, x);
  end

  assign obs_state = force_obs ? obs_force_val : circ_q;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issue one command; xs/obs hold the per-cycle x and circuit state from the first
  // STEER cycle through the exit cycle (bit/field i = cycle i).
  task automatic run_cmd(input logic [1:0] tgt, input logic [1:0] st, input logic er,
                         input logic [3:0] xs, input logic [7:0] ob, input int hold);
    exp_t       want;
    exp_t       got;
    int         cyc;
    logic [3:0] xt;
    logic [7:0] ot;
    want.steps = st;
    want.err   = er;
    want.lat   = int'(st) + 1;
    want.xs    = xs;
    want.obs   = ob;
    sb.push_back(want);
    cyc = 0;
    xt  = '0;
    ot  = '0;

    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    check("x_idle", x, |circ_q);
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;

    while (!rsp_valid && cyc < 8) begin
      if (cyc < 4) begin
        xt[cyc]        = x;
        ot[2*cyc +: 2] = obs_state;
      end
      check("cmd_ready_busy", cmd_ready, 1'b0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end

    got = sb.pop_front();
    if (!rsp_valid) begin
      check("rsp_timeout", rsp_valid, 1'b1);
      return;
    end
    check("rsp_steps", rsp_steps, got.steps);
    check("rsp_err", rsp_err, got.err);
    check("latency", cyc[7:0], got.lat[7:0]);
    check("x_trace", xt, got.xs);
    check("obs_trace", ot, got.obs);

    for (int i = 0; i < hold; i++) begin
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_steps", rsp_steps, got.steps);
      check("hold_err", rsp_err, got.err);
      check("hold_cmd_ready", cmd_ready, 1'b0);
      check("hold_x", x, |circ_q);
      @(posedge clk);
      @(negedge clk);
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done_valid", rsp_valid, 1'b0);
    check("rsp_done_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    cmd_valid     = 1'b0;
    cmd_target    = 2'b00;
    rsp_ready     = 1'b0;
    force_obs     = 1'b0;
    obs_force_val = 2'b00;

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_x", x, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_steps", rsp_steps, 2'd0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_chk_err", chk_err, 1'b0);
    reset = 1'b0;

    // From 00: target 00 is already reached.
    run_cmd(2'b00, 2'd0, 1'b0, 4'b0000, 8'h00, 0);
    // From 00: longest path 00->11->01->10, response held three cycles.
    run_cmd(2'b10, 2'd3, 1'b0, 4'b1101, 8'h9C, 3);
    // From 11: 00 is unreachable.
    run_cmd(2'b00, 2'd0, 1'b1, 4'b0001, 8'h03, 1);
    // From 11: one step to 01, then drift.
    run_cmd(2'b01, 2'd1, 1'b0, 4'b0010, 8'h07, 0);
    // From 11: target 11 is already reached.
    run_cmd(2'b11, 2'd0, 1'b0, 4'b0001, 8'h03, 0);

    // One-cycle observed-state disagreement while the model sits in 11.
    @(negedge clk);
    check("chk_before", chk_err, 1'b0);
    check("model_at_11", x, 1'b1);
    force_obs     = 1'b1;
    obs_force_val = 2'b10;
    @(negedge clk);
    force_obs = 1'b0;
`ifdef SEQ_STEER_CHECK_EN
    check("chk_set", chk_err, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("chk_sticky", chk_err, 1'b1);
    end
`else
    check("chk_tied", chk_err, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("chk_tied_hold", chk_err, 1'b0);
    end
`endif

    reset = 1'b1;
    @(negedge clk);
    check("chk_cleared", chk_err, 1'b0);
    reset = 1'b0;

    // Reset in STEER after one step towards 10.
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_target = 2'b10;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_first_x", x, 1'b1);
    @(posedge clk);
    #2;
    check("mid_busy", cmd_ready, 1'b0);
    check("mid_steps", rsp_steps, 2'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_x", x, 1'b0);
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_ready", cmd_ready, 1'b1);
    check("mid_rst_steps", rsp_steps, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid_no_rsp", rsp_valid, 1'b0);
    end

    // Model must be back in 00: one step to 11.
    run_cmd(2'b11, 2'd1, 1'b0, 4'b0011, 8'h0C, 0);

    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
